// File: rtl/lcd_pkg.sv
// Shared LCD controller definitions: FSM states, HD44780 init ROM,
// command-timing constants and the ns-to-cycles helper.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    INIT_SETUP,
    INIT_PULSE,
    INIT_WAIT,
    IDLE,
    SETUP,
    PULSE,
    EXEC
  } lcd_state_t;

  localparam int INIT_LEN = 7;
  localparam int T_SU     = 2;

  localparam longint NS_PER_S   = 64'sd1_000_000_000;
  localparam longint T_PWR_NS   = 64'sd15_000_000;
  localparam longint T_EN_NS    = 64'sd250;
  localparam longint T_SHORT_NS = 64'sd40_000;
  localparam longint T_LONG_NS  = 64'sd1_640_000;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Rounds up so every wait is at least as long as the panel needs.
  function automatic int ns_to_cycles(input longint clk_hz, input longint ns);
    longint cyc;
    cyc = (ns * clk_hz + (NS_PER_S - 64'sd1)) / NS_PER_S;
    return (cyc < 64'sd1) ? 1 : int'(cyc);
  endfunction

  function automatic logic [7:0] init_cmd(input int idx);
    case (idx)
      0, 1, 2, 3: return 8'h38;
      4:          return 8'h0C;
      5:          return 8'h01;
      6:          return 8'h06;
      default:    return 8'h00;
    endcase
  endfunction

  function automatic longint init_wait_ns(input int idx);
    case (idx)
      0:       return 64'sd4_100_000;
      1:       return 64'sd100_000;
      5:       return T_LONG_NS;
      default: return T_SHORT_NS;
    endcase
  endfunction

endpackage

// File: rtl/lcd_fifo.sv
// Small first-word-fall-through FIFO buffering CPU writes to the LCD bus.
module lcd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             do_push, do_pop;

  assign full  = (count_reg == (PW + 1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign dout  = mem[rd_ptr_reg];

  // A simultaneous pop frees the slot, so a push is accepted even when full.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + (PW + 1)'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - (PW + 1)'(1);
    end
  end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 8-bit write-only controller: timed power-up init, then replays
// buffered CPU register writes with setup/enable/execute timing.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_io_lcd,
  input  logic        i_lcd_wr,
  output logic        o_full,
  output logic        o_busy,
  output logic        o_init_done,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on
);

  localparam longint HZ    = longint'(CLK_HZ);
  localparam int     T_PWR = ns_to_cycles(HZ, T_PWR_NS);
  localparam int     T_EN  = ns_to_cycles(HZ, T_EN_NS);
  localparam int     CNT_W = $clog2(T_PWR + 1);

  // Counter reload values are "length - 1"; PWRUP spends one cycle arming.
  localparam logic [CNT_W-1:0] LD_PWR   = CNT_W'(T_PWR - 2);
  localparam logic [CNT_W-1:0] LD_SU    = CNT_W'(T_SU - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] LD_SHORT = CNT_W'(ns_to_cycles(HZ, T_SHORT_NS) - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(ns_to_cycles(HZ, T_LONG_NS) - 1);

  lcd_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next, idx_inc;
  logic [7:0]       data_reg, data_next;
  logic             rs_reg, rs_next;
  logic             en_reg, en_next;
  logic             done_reg, done_next;
  logic             armed_reg, armed_next;
  logic             on_reg;

  logic             fifo_pop, fifo_empty;
  logic [8:0]       fifo_head;
  logic             is_long;
  logic             unused_io;

  logic [7:0]       init_cmd_rom  [8];
  logic [CNT_W-1:0] init_wait_rom [8];

  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_init_rom
    assign init_cmd_rom[gi]  = init_cmd(gi);
    assign init_wait_rom[gi] = CNT_W'(ns_to_cycles(HZ, init_wait_ns(gi)) - 1);
  end

  lcd_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (i_lcd_wr),
    .pop   (fifo_pop),
    .din   ({i_io_lcd[9], i_io_lcd[7:0]}),
    .dout  (fifo_head),
    .full  (o_full),
    .empty (fifo_empty)
  );

  assign unused_io = ^{i_io_lcd[30:10], i_io_lcd[8]};
  assign idx_inc   = idx_reg + 3'd1;
  assign is_long   = !rs_reg && ((data_reg == CMD_CLEAR) || (data_reg == CMD_HOME));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= PWRUP;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      data_reg  <= '0;
      rs_reg    <= 1'b0;
      en_reg    <= 1'b0;
      done_reg  <= 1'b0;
      armed_reg <= 1'b0;
      on_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      data_reg  <= data_next;
      rs_reg    <= rs_next;
      en_reg    <= en_next;
      done_reg  <= done_next;
      armed_reg <= armed_next;
      on_reg    <= i_io_lcd[31];
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = (cnt_reg != '0) ? cnt_reg - CNT_W'(1) : cnt_reg;
    idx_next   = idx_reg;
    data_next  = data_reg;
    rs_next    = rs_reg;
    en_next    = 1'b0;
    done_next  = done_reg;
    armed_next = armed_reg;
    fifo_pop   = 1'b0;
    case (state_reg)
      PWRUP: begin
        if (!armed_reg) begin
          armed_next = 1'b1;
          cnt_next   = LD_PWR;
        end else if (cnt_reg == '0) begin
          state_next = INIT_SETUP;
          idx_next   = '0;
          data_next  = init_cmd_rom[0];
          rs_next    = 1'b0;
          cnt_next   = LD_SU;
        end
      end
      INIT_SETUP: begin
        if (cnt_reg == '0) begin
          state_next = INIT_PULSE;
          en_next    = 1'b1;
          cnt_next   = LD_EN;
        end
      end
      INIT_PULSE: begin
        en_next = 1'b1;
        if (cnt_reg == '0) begin
          state_next = INIT_WAIT;
          en_next    = 1'b0;
          cnt_next   = init_wait_rom[idx_reg];
        end
      end
      INIT_WAIT: begin
        if (cnt_reg == '0) begin
          if (idx_reg == 3'(INIT_LEN - 1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = INIT_SETUP;
            idx_next   = idx_inc;
            data_next  = init_cmd_rom[idx_inc];
            cnt_next   = LD_SU;
          end
        end
      end
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = SETUP;
          rs_next    = fifo_head[8];
          data_next  = fifo_head[7:0];
          cnt_next   = LD_SU;
        end
      end
      SETUP: begin
        if (cnt_reg == '0) begin
          state_next = PULSE;
          en_next    = 1'b1;
          cnt_next   = LD_EN;
        end
      end
      PULSE: begin
        en_next = 1'b1;
        if (cnt_reg == '0) begin
          state_next = EXEC;
          en_next    = 1'b0;
          cnt_next   = is_long ? LD_LONG : LD_SHORT;
        end
      end
      EXEC: begin
        if (cnt_reg == '0) state_next = IDLE;
      end
      default: state_next = PWRUP;
    endcase
  end

  assign o_busy      = !fifo_empty || (state_reg != IDLE) || !done_reg;
  assign o_init_done = done_reg;
  assign o_lcd_data  = data_reg;
  assign o_lcd_rs    = rs_reg;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_en    = en_reg;
  assign o_lcd_on    = on_reg;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl at 1 MHz: expected bus words are queued when
// driven (or at init) and checked on each EN rising edge, plus timing checks.
module tb_lcd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] io_lcd = '0;
  logic        lcd_wr = 1'b0;
  logic        full, busy, init_done;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, lcd_on;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [8:0] sb [$];
  int         rises [$];
  int         falls [$];

  lcd_ctrl #(
    .CLK_HZ     (1_000_000),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_io_lcd    (io_lcd),
    .i_lcd_wr    (lcd_wr),
    .o_full      (full),
    .o_busy      (busy),
    .o_init_done (init_done),
    .o_lcd_data  (lcd_data),
    .o_lcd_rs    (lcd_rs),
    .o_lcd_rw    (lcd_rw),
    .o_lcd_en    (lcd_en),
    .o_lcd_on    (lcd_on)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic push_init();
    logic [7:0] cmds [7];
    cmds = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    for (int i = 0; i < 7; i++) sb.push_back({1'b0, cmds[i]});
  endtask

  function automatic logic [31:0] mk_io(input logic on, input logic [8:0] w);
    // bit 8 set as junk: it must be ignored by the DUT
    return {on, 21'h0, w[8], 1'b1, w[7:0]};
  endfunction

  // Bus monitor: one line per EN pulse, scoreboard compare, setup/hold checks.
  logic       prev_en = 1'b0, h1_en = 1'b0, h2_en = 1'b0;
  logic [8:0] h1 = '0, h2 = '0, rise_bus = '0;
  int         en_len = 0;

  always @(negedge clk) begin
    logic [8:0] bus;
    logic [8:0] exp_w;
    bus = {lcd_rs, lcd_data};
    if (!rst) begin
      if (lcd_en && !prev_en) begin
        rises.push_back(cyc);
        $display("bus write cyc=%0d rs=%0d data=0x%02h", cyc, lcd_rs, lcd_data);
        chk("rw_low", {31'd0, lcd_rw}, 32'd0);
        chk("setup_en_low", {30'd0, h2_en, h1_en}, 32'd0);
        chk("setup_stable", {31'd0, (h1 == bus) && (h2 == bus)}, 32'd1);
        chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
          exp_w = sb.pop_front();
          chk("bus_word", {23'd0, bus}, {23'd0, exp_w});
        end
        en_len = 1;
        rise_bus = bus;
      end else if (lcd_en) begin
        en_len++;
      end else if (prev_en) begin
        falls.push_back(cyc);
        chk("en_width", en_len, 1);
        chk("hold_at_fall", {23'd0, bus}, {23'd0, rise_bus});
      end
    end
    h2 = h1; h1 = bus;
    h2_en = h1_en; h1_en = lcd_en;
    prev_en = lcd_en;
  end

  task automatic wait_not_busy(input int limit);
    for (int n = 0; n < limit; n++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("busy_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_write(input logic [8:0] w, input int exp_exec);
    int b, fb, wr_edge;
    b = rises.size();
    fb = falls.size();
    io_lcd = mk_io(1'b1, w);
    lcd_wr = 1'b1;
    sb.push_back(w);
    @(negedge clk);
    lcd_wr = 1'b0;
    wr_edge = cyc;
    wait_not_busy(5000);
    chk("write_rises", rises.size() - b, 1);
    if (rises.size() > b) chk("issue_lat", rises[b] - wr_edge, 3);
    if (falls.size() > fb) chk("exec_len", cyc - falls[falls.size() - 1], exp_exec);
    chk("hold_after", {23'd0, lcd_rs, lcd_data}, {23'd0, w});
  endtask

  initial begin
    logic [8:0] words [6];
    int waits [7];
    int rel, done_cyc, model_cnt, b;
    words = '{9'h141, 9'h001, 9'h081, 9'h142, 9'h143, 9'h144};
    waits = '{4100, 100, 40, 40, 40, 1640, 40};

    // reset state, with display power requested during reset
    io_lcd = 32'h8000_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en", {31'd0, lcd_en}, 32'd0);
    chk("rst_done", {31'd0, init_done}, 32'd0);
    chk("rst_bus", {23'd0, lcd_rs, lcd_data}, 32'd0);
    chk("rst_on", {31'd0, lcd_on}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);

    // release, then 6 back-to-back strobes during power-up
    push_init();
    rel = cyc;
    rst = 1'b0;
    model_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      io_lcd = mk_io(1'b1, words[i]);
      lcd_wr = 1'b1;
      if (model_cnt < 4) begin
        sb.push_back(words[i]);
        model_cnt++;
      end
      @(negedge clk);
    end
    lcd_wr = 1'b0;
    chk("full_after_6", {31'd0, full}, 32'd1);
    chk("on_follow", {31'd0, lcd_on}, 32'd1);

    for (int n = 0; n < 30000; n++) begin
      if (init_done) break;
      @(negedge clk);
    end
    done_cyc = cyc;
    chk("init_done_timeout", {31'd0, init_done}, 32'd1);
    chk("init_rises", rises.size(), 7);
    if (rises.size() >= 7) begin
      chk("pwrup_len", rises[0] - rel, 15002);
      for (int i = 0; i < 6; i++) chk("init_gap", rises[i + 1] - rises[i], waits[i] + 3);
      chk("done_delay", done_cyc - rises[6], 41);
    end

    // buffered words drain in order after init
    wait_not_busy(10000);
    chk("drain_rises", rises.size(), 11);
    if (rises.size() >= 11) begin
      chk("first_issue", rises[7] - done_cyc, 3);
      chk("gap_data", rises[8] - rises[7], 44);
      chk("gap_clear", rises[9] - rises[8], 1644);
      chk("gap_0x81", rises[10] - rises[9], 44);
    end
    if (falls.size() > 0) chk("drain_busy_drop", cyc - falls[falls.size() - 1], 40);
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_full", {31'd0, full}, 32'd0);

    // single writes: data, clear, home, non-clear opcodes
    do_write(9'h141, 40);
    do_write(9'h001, 1640);
    do_write(9'h081, 40);
    do_write(9'h002, 1640);
    do_write(9'h101, 40);

    // display power follows bit 31 without a strobe
    @(negedge clk);
    io_lcd[31] = 1'b0;
    @(posedge clk); #1;
    chk("on_off", {31'd0, lcd_on}, 32'd0);
    io_lcd[31] = 1'b1;
    @(posedge clk); #1;
    chk("on_on", {31'd0, lcd_on}, 32'd1);
    b = rises.size();
    repeat (50) @(negedge clk);
    chk("on_no_xfer", rises.size(), b);
    chk("on_busy", {31'd0, busy}, 32'd0);

    // reset while EN is high, with two words still buffered
    for (int i = 0; i < 3; i++) begin
      io_lcd = mk_io(1'b1, words[3 + i]);
      lcd_wr = 1'b1;
      sb.push_back(words[3 + i]);
      @(negedge clk);
    end
    lcd_wr = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (lcd_en) break;
      @(negedge clk);
    end
    chk("en_seen", {31'd0, lcd_en}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_en", {31'd0, lcd_en}, 32'd0);
    chk("mid_rst_done", {31'd0, init_done}, 32'd0);
    chk("mid_rst_on", {31'd0, lcd_on}, 32'd0);
    chk("mid_rst_bus", {23'd0, lcd_rs, lcd_data}, 32'd0);
    chk("mid_rst_full", {31'd0, full}, 32'd0);
    sb.delete();
    push_init();
    repeat (3) @(negedge clk);
    b = rises.size();
    rel = cyc;
    rst = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      if (rises.size() > b) break;
      @(negedge clk);
    end
    chk("rerun_rise", rises.size() - b, 1);
    if (rises.size() > b) chk("rerun_pwrup_len", rises[b] - rel, 15002);
    for (int n = 0; n < 10000; n++) begin
      if (init_done) break;
      @(negedge clk);
    end
    chk("rerun_done", {31'd0, init_done}, 32'd1);
    repeat (100) @(negedge clk);
    chk("rerun_rises", rises.size() - b, 7);
    chk("rerun_idle", {31'd0, busy}, 32'd0);
    chk("rerun_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, the i_clk frequency used to derive all wait counts.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the number of buffered LCD write words (power of 2, at least 2).
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port i_io_lcd, input, 32, the CPU LCD register word: [31] display power, [9] RS, [7:0] data; other bits are ignored.
REQ-006 SHALL have port i_lcd_wr, input, 1, a one-cycle strobe when the CPU writes the LCD register.
REQ-007 SHALL have port o_full, output, 1, asserted when the FIFO holds FIFO_DEPTH words.
REQ-008 SHALL have port o_busy, output, 1, asserted when the FIFO is non-empty, a transfer is running, or init is incomplete.
REQ-009 SHALL have port o_init_done, output, 1, asserted once the power-up init sequence has completed.
REQ-010 SHALL have ports o_lcd_data (8), o_lcd_rs (1), o_lcd_rw (1), o_lcd_en (1), o_lcd_on (1), all outputs, driving the HD44780 8-bit bus.

Function
REQ-011 SHALL push {i_io_lcd[9], i_io_lcd[7:0]} into the FIFO on i_lcd_wr when not full; a strobe while full is dropped with no state change.
REQ-012 SHALL register o_lcd_on from i_io_lcd[31] every cycle, independent of FIFO and FSM.
REQ-013 SHALL hold o_lcd_rw at 0 at all times (write-only, timed; busy flag is never read).
REQ-014 SHALL use FSM states PWRUP, INIT_SETUP, INIT_PULSE, INIT_WAIT, IDLE, SETUP, PULSE, EXEC.
REQ-015 PWRUP SHALL wait T_PWR = 15 ms of cycles, then go to INIT_SETUP with init index 0.
REQ-016 The init sequence SHALL be the commands 0x38, 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with RS=0, followed by waits of 4.1 ms, 100 us, 40 us, 40 us, 40 us, 1.64 ms and 40 us respectively.
REQ-017 Each bus transfer SHALL drive data and RS for T_SU = 2 cycles with EN=0, then EN=1 for T_EN = ceil(CLK_HZ*250 ns) cycles (min 1), then EN=0.
REQ-018 After EN falls, data and RS SHALL be held stable through the whole wait state.
REQ-019 After the last init wait, the FSM SHALL assert o_init_done (sticky until reset) and enter IDLE.
REQ-020 IDLE SHALL pop the FIFO head in the same cycle it observes non-empty and go to SETUP; data/RS update on the next edge.
REQ-021 EXEC SHALL wait 1.64 ms when RS=0 and data is 0x01 or 0x02 (clear/home), otherwise 40 us, then return to IDLE.
REQ-022 A push and a pop in the same cycle SHALL leave the count unchanged, and a push in that cycle SHALL be accepted even when the FIFO was full before it.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; words SHALL leave in strict arrival order.
REQ-024 Strobes during PWRUP/INIT SHALL be buffered, and SHALL be issued only after o_init_done.
REQ-025 A single down-counter SHALL time all waits; it SHALL be sized for the largest count (T_PWR) at CLK_HZ, with all counts computed at elaboration.

Reset
REQ-026 i_rst SHALL asynchronously force state PWRUP, an empty FIFO and a cleared counter.
REQ-027 i_rst SHALL asynchronously force o_init_done=0, o_lcd_en=0, o_lcd_rs=0, o_lcd_data=0x00 and o_lcd_on=0.
REQ-028 Reset asserted mid-transfer SHALL drop EN immediately, discard in-flight and buffered words, and rerun the full init after release.

Structure
REQ-029 Package lcd_pkg SHALL hold the FSM state enum, the init command and wait ROM constants, the clear/home opcodes, and a function converting ns to cycles given CLK_HZ.
REQ-030 The FIFO SHALL be a sub-module lcd_fifo (parameterised width 9, depth FIFO_DEPTH, with full/empty/push/pop).

Verification (CLK_HZ=1_000_000 for sim)
REQ-031 Release reset -> EN stays 0 for 15000 cycles; the first EN pulse carries 0x38 with RS=0; o_init_done rises after the 7th command plus its 40-cycle wait.
REQ-032 After init, write 0x200 | 0x41 -> RS=1 and data 0x41 stable 2 cycles before EN; EN high 1 cycle; o_busy drops 40 cycles after EN falls.
REQ-033 Write 0x001 -> EXEC lasts 1640 cycles; write 0x081 -> 40 cycles.
REQ-034 Issue 6 back-to-back strobes during PWRUP with FIFO_DEPTH=4 -> o_full is asserted; words 5-6 are dropped; words 1-4 appear on the bus in order after init.
REQ-035 Assert i_rst while EN=1 -> EN, o_init_done and o_lcd_on are 0 the same cycle; the FIFO is empty; the 15000-cycle PWRUP restarts after release.
REQ-036 Toggle i_io_lcd[31] with no strobe -> o_lcd_on follows one cycle later; the FSM and FIFO are unaffected.
